// File: rtl/flit_rank_stage.sv
// flit_rank_stage: BLESS router stage ahead of the port allocator chain.
// Latches four link flits plus one local injection flit, increments age
// (saturating), computes the productive-port request vector per flit and
// presents the valid flits packed into slots 0..3 of a registered output.
// Optional feature macro: AGE_RANK_EN. When defined, slots are ordered
// oldest-first (ties to the lower position N<E<S<W). When undefined, the
// sorter is absent and slots follow fixed position order, packed low.
module flit_rank_stage #(
  parameter int NUM_PORT  = 5,
  parameter int COORD_W   = 3,
  parameter int AGE_W     = 8,
  parameter int PAYLOAD_W = 32,
  localparam int FLIT_W   = 2*COORD_W + AGE_W + PAYLOAD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      cur_x,
  input  logic [COORD_W-1:0]      cur_y,
  input  logic [3:0]              link_valid,
  input  logic [4*FLIT_W-1:0]     link_flit,
  input  logic                    inj_valid,
  input  logic [FLIT_W-1:0]       inj_flit,
  output logic                    inj_ack,
  output logic [3:0]              rank_valid,
  output logic [4*FLIT_W-1:0]     rank_flit,
  output logic [4*NUM_PORT-1:0]   rank_req
);

  localparam int AGE_LSB = PAYLOAD_W;
  localparam int DY_LSB  = PAYLOAD_W + AGE_W;
  localparam int DX_LSB  = PAYLOAD_W + AGE_W + COORD_W;

  typedef struct packed {
    logic                vld;
`ifdef AGE_RANK_EN
    logic [1:0]          pos;
`endif
    logic [FLIT_W-1:0]   flit;
    logic [NUM_PORT-1:0] req;
  } ent_t;

  ent_t       ent   [4];
  ent_t       slot_d[4];
  logic [1:0] free_idx;

  logic [3:0]            rank_valid_q;
  logic [4*FLIT_W-1:0]   rank_flit_q;
  logic [4*NUM_PORT-1:0] rank_req_q;

  // Productive directions; comparisons are unsigned.
  function automatic logic [NUM_PORT-1:0] route(
    input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    logic [NUM_PORT-1:0] r;
    r = '0;
    if (dy > cy) r[0] = 1'b1;
    if (dx > cx) r[1] = 1'b1;
    if (dy < cy) r[2] = 1'b1;
    if (dx < cx) r[3] = 1'b1;
    if ((dx == cx) && (dy == cy)) r[4] = 1'b1;
    return r;
  endfunction

  // Injection only when at least one link position is free.
  assign inj_ack = inj_valid & ~(&link_valid);

  // Lowest-index free link position, taken by an acked injection flit.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!link_valid[i]) free_idx = 2'(i);
    end
  end

  // Per-position flit selection, age increment and routing.
  always_comb begin
    logic [FLIT_W-1:0] src;
    logic [AGE_W-1:0]  age;
    logic              vld;
    for (int i = 0; i < 4; i++) begin
      ent[i] = '0;
`ifdef AGE_RANK_EN
      ent[i].pos = 2'(i);
`endif
      src = link_flit[i*FLIT_W +: FLIT_W];
      vld = link_valid[i];
      if (!link_valid[i] && inj_ack && (free_idx == 2'(i))) begin
        src = inj_flit;
        // Injected flits always enter at age 0.
        src[AGE_LSB +: AGE_W] = '0;
        vld = 1'b1;
      end
      age = src[AGE_LSB +: AGE_W];
      if (age != {AGE_W{1'b1}}) age = age + 1'b1;
      if (vld) begin
        ent[i].vld  = 1'b1;
        ent[i].flit = src;
        ent[i].flit[AGE_LSB +: AGE_W] = age;
        ent[i].req  = route(src[DX_LSB +: COORD_W], src[DY_LSB +: COORD_W], cur_x, cur_y);
      end
    end
  end

`ifdef AGE_RANK_EN
  // Strict total order: valid first, then higher age, then lower position.
  function automatic logic first_of(input ent_t a, input ent_t b);
    logic [AGE_W+2:0] ka, kb;
    ka = {a.vld, a.flit[AGE_LSB +: AGE_W], ~a.pos};
    kb = {b.vld, b.flit[AGE_LSB +: AGE_W], ~b.pos};
    return ka > kb;
  endfunction

  function automatic ent_t pick_hi(input ent_t a, input ent_t b);
    return first_of(a, b) ? a : b;
  endfunction

  function automatic ent_t pick_lo(input ent_t a, input ent_t b);
    return first_of(a, b) ? b : a;
  endfunction

  // 5-comparator 4-input sorting network; invalid entries are all-zero data
  // and sink to the high slots.
  always_comb begin
    ent_t a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = pick_hi(ent[0], ent[1]);
    a1 = pick_lo(ent[0], ent[1]);
    a2 = pick_hi(ent[2], ent[3]);
    a3 = pick_lo(ent[2], ent[3]);
    b0 = pick_hi(a0, a2);
    b2 = pick_lo(a0, a2);
    b1 = pick_hi(a1, a3);
    b3 = pick_lo(a1, a3);
    slot_d[0] = b0;
    slot_d[1] = pick_hi(b1, b2);
    slot_d[2] = pick_lo(b1, b2);
    slot_d[3] = b3;
  end
`else
  // Fixed position order, valid entries packed into the low slots.
  always_comb begin
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int k = 0; k < 4; k++) slot_d[k] = '0;
    for (int i = 0; i < 4; i++) begin
      if (ent[i].vld) begin
        slot_d[cnt] = ent[i];
        cnt = cnt + 2'd1;
      end
    end
  end
`endif

  // Output register; empty slots carry zero flit and request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rank_valid_q <= '0;
      rank_flit_q  <= '0;
      rank_req_q   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        rank_valid_q[k]                       <= slot_d[k].vld;
        rank_flit_q[k*FLIT_W +: FLIT_W]       <= slot_d[k].flit;
        rank_req_q[k*NUM_PORT +: NUM_PORT]    <= slot_d[k].req;
      end
    end
  end

  assign rank_valid = rank_valid_q;
  assign rank_flit  = rank_flit_q;
  assign rank_req   = rank_req_q;

endmodule

// File: tb/tb_flit_rank_stage.sv
// Directed table-driven bench for flit_rank_stage. Expected slot contents
// are hand-computed; ordering vectors carry both ranked and fixed-order
// expectations selected by AGE_RANK_EN.
module tb_flit_rank_stage;
  localparam int NUM_PORT = 5;
  localparam int COORD_W  = 3;
  localparam int AGE_W    = 8;
  localparam int PAYLOAD_W = 32;
  localparam int FLIT_W   = 2*COORD_W + AGE_W + PAYLOAD_W;

  logic                  clk;
  logic                  rst_n;
  logic [COORD_W-1:0]    cur_x, cur_y;
  logic [3:0]            link_valid;
  logic [4*FLIT_W-1:0]   link_flit;
  logic                  inj_valid;
  logic [FLIT_W-1:0]     inj_flit;
  logic                  inj_ack;
  logic [3:0]            rank_valid;
  logic [4*FLIT_W-1:0]   rank_flit;
  logic [4*NUM_PORT-1:0] rank_req;

  int errors = 0;
  int checks = 0;

  flit_rank_stage dut (
    .clk(clk), .rst_n(rst_n), .cur_x(cur_x), .cur_y(cur_y),
    .link_valid(link_valid), .link_flit(link_flit),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ack(inj_ack),
    .rank_valid(rank_valid), .rank_flit(rank_flit), .rank_req(rank_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fields written as {W,S,E,N} for inputs and {slot3..slot0} for outputs.
  // src code: 0..3 link position, 4 injection flit, 7 empty slot.
  typedef struct packed {
    logic [3:0]  lv;
    logic [31:0] age;
    logic [11:0] dx;
    logic [11:0] dy;
    logic        iv;
    logic [2:0]  idx;
    logic [2:0]  idy;
    logic        ack;
    logic [3:0]  vld;
    logic [11:0] src;
    logic [31:0] eage;
    logic [19:0] ereq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    link_valid = v.lv;
    for (int i = 0; i < 4; i++)
      link_flit[i*FLIT_W +: FLIT_W] = {v.dx[i*3 +: 3], v.dy[i*3 +: 3], v.age[i*8 +: 8], 32'hA000_0000 | i};
    inj_valid = v.iv;
    inj_flit  = {v.idx, v.idy, 8'd0, 32'hC0DE_0000};
  endtask

  initial begin
    vec_t v;
    logic [2:0] s;
    logic [FLIT_W-1:0] ef;

    // routing: N flit dst (4,1), age 3 -> 4, req E|S
    vecs.push_back('{4'b0001, {8'd77,8'd66,8'd55,8'd3}, {3'd1,3'd1,3'd1,3'd4}, {3'd5,3'd5,3'd5,3'd1},
                     1'b0, 3'd0, 3'd0, 1'b0, 4'b0001, {3'd7,3'd7,3'd7,3'd0},
                     {8'd0,8'd0,8'd0,8'd4}, {5'd0,5'd0,5'd0,5'b00110}});
    // ranking: ages N5 E9 S9 W2
`ifdef AGE_RANK_EN
    vecs.push_back('{4'b1111, {8'd2,8'd9,8'd9,8'd5}, {3'd0,3'd2,3'd5,3'd2}, {3'd2,3'd0,3'd2,3'd5},
                     1'b0, 3'd0, 3'd0, 1'b0, 4'b1111, {3'd3,3'd0,3'd2,3'd1},
                     {8'd3,8'd6,8'd10,8'd10}, {5'b01000,5'b00001,5'b00100,5'b00010}});
`else
    vecs.push_back('{4'b1111, {8'd2,8'd9,8'd9,8'd5}, {3'd0,3'd2,3'd5,3'd2}, {3'd2,3'd0,3'd2,3'd5},
                     1'b0, 3'd0, 3'd0, 1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0},
                     {8'd3,8'd10,8'd10,8'd6}, {5'b01000,5'b00100,5'b00010,5'b00001}});
`endif
    // injection blocked by four valid links
`ifdef AGE_RANK_EN
    vecs.push_back('{4'b1111, {8'd40,8'd30,8'd20,8'd10}, {3'd2,3'd2,3'd2,3'd2}, {3'd2,3'd2,3'd2,3'd2},
                     1'b1, 3'd5, 3'd5, 1'b0, 4'b1111, {3'd0,3'd1,3'd2,3'd3},
                     {8'd11,8'd21,8'd31,8'd41}, {5'b10000,5'b10000,5'b10000,5'b10000}});
`else
    vecs.push_back('{4'b1111, {8'd40,8'd30,8'd20,8'd10}, {3'd2,3'd2,3'd2,3'd2}, {3'd2,3'd2,3'd2,3'd2},
                     1'b1, 3'd5, 3'd5, 1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0},
                     {8'd41,8'd31,8'd21,8'd11}, {5'b10000,5'b10000,5'b10000,5'b10000}});
`endif
    // injection into free S position, dst = cur, ties at age 1
    vecs.push_back('{4'b1011, {8'd0,8'd99,8'd0,8'd4}, {3'd2,3'd6,3'd1,3'd3}, {3'd7,3'd6,3'd1,3'd3},
                     1'b1, 3'd2, 3'd2, 1'b1, 4'b1111, {3'd3,3'd4,3'd1,3'd0},
                     {8'd1,8'd1,8'd1,8'd5}, {5'b00001,5'b10000,5'b01100,5'b00011}});
    // saturation: S age 255 stays 255
`ifdef AGE_RANK_EN
    vecs.push_back('{4'b0110, {8'd9,8'd255,8'd100,8'd9}, {3'd0,3'd0,3'd7,3'd0}, {3'd0,3'd7,3'd0,3'd0},
                     1'b0, 3'd0, 3'd0, 1'b0, 4'b0011, {3'd7,3'd7,3'd1,3'd2},
                     {8'd0,8'd0,8'd101,8'd255}, {5'd0,5'd0,5'b00110,5'b01001}});
`else
    vecs.push_back('{4'b0110, {8'd9,8'd255,8'd100,8'd9}, {3'd0,3'd0,3'd7,3'd0}, {3'd0,3'd7,3'd0,3'd0},
                     1'b0, 3'd0, 3'd0, 1'b0, 4'b0011, {3'd7,3'd7,3'd2,3'd1},
                     {8'd0,8'd0,8'd255,8'd101}, {5'd0,5'd0,5'b01001,5'b00110}});
`endif
    // nothing valid, junk data
    vecs.push_back('{4'b0000, {8'd1,8'd2,8'd3,8'd4}, {3'd1,3'd2,3'd3,3'd4}, {3'd4,3'd3,3'd2,3'd1},
                     1'b0, 3'd6, 3'd6, 1'b0, 4'b0000, {3'd7,3'd7,3'd7,3'd7},
                     32'd0, 20'd0});
    // injection alone takes N position
    vecs.push_back('{4'b0000, {8'd1,8'd2,8'd3,8'd4}, {3'd1,3'd2,3'd3,3'd4}, {3'd4,3'd3,3'd2,3'd1},
                     1'b1, 3'd0, 3'd0, 1'b1, 4'b0001, {3'd7,3'd7,3'd7,3'd4},
                     {8'd0,8'd0,8'd0,8'd1}, {5'd0,5'd0,5'd0,5'b01100}});
    // injection into E position amid N and S
`ifdef AGE_RANK_EN
    vecs.push_back('{4'b0101, {8'd50,8'd20,8'd60,8'd7}, {3'd1,3'd6,3'd1,3'd2}, {3'd1,3'd6,3'd1,3'd2},
                     1'b1, 3'd2, 3'd3, 1'b1, 4'b0111, {3'd7,3'd4,3'd0,3'd2},
                     {8'd0,8'd1,8'd8,8'd21}, {5'd0,5'b00001,5'b10000,5'b00011}});
`else
    vecs.push_back('{4'b0101, {8'd50,8'd20,8'd60,8'd7}, {3'd1,3'd6,3'd1,3'd2}, {3'd1,3'd6,3'd1,3'd2},
                     1'b1, 3'd2, 3'd3, 1'b1, 4'b0111, {3'd7,3'd2,3'd4,3'd0},
                     {8'd0,8'd21,8'd1,8'd8}, {5'd0,5'b00011,5'b00001,5'b10000}});
`endif

    cur_x = 3'd2; cur_y = 3'd2;
    link_valid = 4'b1111; link_flit = '1; inj_valid = 1'b1; inj_flit = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_valid", 64'(rank_valid), 64'd0);
    chk("reset_req",   64'(rank_req),   64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_flit", 64'(rank_flit != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("v%0d inj_ack", n), 64'(inj_ack), 64'(v.ack));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rank_valid", n), 64'(rank_valid), 64'(v.vld));
      for (int k = 0; k < 4; k++) begin
        s = v.src[k*3 +: 3];
        if (s == 3'd7)      ef = '0;
        else if (s == 3'd4) ef = {v.idx, v.idy, v.eage[k*8 +: 8], 32'hC0DE_0000};
        else                ef = {v.dx[s*3 +: 3], v.dy[s*3 +: 3], v.eage[k*8 +: 8], 32'hA000_0000 | 32'(s)};
        chk($sformatf("v%0d flit%0d", n, k), 64'(rank_flit[k*FLIT_W +: FLIT_W]), 64'(ef));
        chk($sformatf("v%0d req%0d", n, k), 64'(rank_req[k*NUM_PORT +: NUM_PORT]), 64'(v.ereq[k*5 +: 5]));
      end
    end

    // Asynchronous reset mid-traffic, between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rank_valid), 64'd0);
    chk("async_rst_flit0", 64'(rank_flit[0 +: FLIT_W]), 64'd0);
    chk("async_rst_req",   64'(rank_req), 64'd0);
    link_valid = 4'b1111;
    inj_valid  = 1'b0;
    for (int i = 0; i < 4; i++)
      link_flit[i*FLIT_W +: FLIT_W] = {3'd2, 3'd2, 8'd0, 32'h5000_0000 | i};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_valid", 64'(rank_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_no_edge", 64'(rank_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("first_capture_valid", 64'(rank_valid), 64'hF);
    chk("first_capture_flit0", 64'(rank_flit[0 +: FLIT_W]), 64'({3'd2, 3'd2, 8'd1, 32'h5000_0000}));
    chk("first_capture_req3",  64'(rank_req[3*NUM_PORT +: NUM_PORT]), 64'(5'b10000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
